// File: rtl/axi4_lite_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite slave BFM.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        IDLE,
        HAVE_AW,
        HAVE_W,
        RESP
    } wr_state_e;

    typedef enum logic {
        RIDLE,
        RDATA
    } rd_state_e;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Word-addressed storage with a byte-enabled write port and a registered read port.
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 1,
    parameter int IDX_W      = 8 * ADDR_BYTES - $clog2(DATA_BYTES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [IDX_W-1:0]          waddr,
    input  logic [DATA_BYTES-1:0]     wstrb,
    input  logic [8*DATA_BYTES-1:0]   wdata,
    input  logic                      re,
    input  logic [IDX_W-1:0]          raddr,
    output logic [8*DATA_BYTES-1:0]   rdata
);

    localparam int DEPTH = 1 << IDX_W;

    logic [8*DATA_BYTES-1:0] mem [DEPTH];

    // Read samples mem before this edge's write lands, so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                for (int b = 0; b < DATA_BYTES; b++) begin
                    if (wstrb[b]) begin
                        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/axi4_lite_slave_bfm.sv
// AXI4-Lite slave model: independent write/read FSMs in front of a byte-enabled register file.
module axi4_lite_slave_bfm
    import axi4_lite_pkg::*;
#(
    parameter int         DATA_BYTES = 4,
    parameter int         ADDR_BYTES = 1,
    parameter logic [1:0] WR_RESP    = 2'b00,
    parameter logic [1:0] RD_RESP    = 2'b00
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [8*ADDR_BYTES-1:0]   awaddr,
    input  logic [2:0]                awprot,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [8*DATA_BYTES-1:0]   wdata,
    input  logic [DATA_BYTES-1:0]     wstrb,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [8*ADDR_BYTES-1:0]   araddr,
    input  logic [2:0]                arprot,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [8*DATA_BYTES-1:0]   rdata,
    output logic [1:0]                rresp,
    output logic                      wr_evt,
    output logic [8*ADDR_BYTES-1:0]   wr_addr,
    output logic [8*DATA_BYTES-1:0]   wr_data
);

    localparam int AW    = 8 * ADDR_BYTES;
    localparam int DW    = 8 * DATA_BYTES;
    localparam int OFF   = $clog2(DATA_BYTES);
    localparam int IDX_W = AW - OFF;

    wr_state_e wr_state, wr_next;
    rd_state_e rd_state, rd_next;

    logic [AW-1:0]         aw_addr_p0;
    logic [DW-1:0]         w_data_p0;
    logic [DATA_BYTES-1:0] w_strb_p0;

    logic                  commit;
    logic [AW-1:0]         cmt_addr;
    logic [DW-1:0]         cmt_data;
    logic [DATA_BYTES-1:0] cmt_strb;
    logic                  rd_re;

    logic unused_ok;
    assign unused_ok = ^{awprot, arprot, araddr};

    // Write channel: commit happens on the edge that completes the second of AW/W.
    always_comb begin
        wr_next  = wr_state;
        awready  = 1'b0;
        wready   = 1'b0;
        commit   = 1'b0;
        cmt_addr = awaddr;
        cmt_data = wdata;
        cmt_strb = wstrb;
        case (wr_state)
            IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
                if (awvalid && wvalid) begin
                    commit  = 1'b1;
                    wr_next = RESP;
                end else if (awvalid) begin
                    wr_next = HAVE_AW;
                end else if (wvalid) begin
                    wr_next = HAVE_W;
                end
            end
            HAVE_AW: begin
                wready   = 1'b1;
                cmt_addr = aw_addr_p0;
                if (wvalid) begin
                    commit  = 1'b1;
                    wr_next = RESP;
                end
            end
            HAVE_W: begin
                awready  = 1'b1;
                cmt_data = w_data_p0;
                cmt_strb = w_strb_p0;
                if (awvalid) begin
                    commit  = 1'b1;
                    wr_next = RESP;
                end
            end
            RESP: begin
                if (bready) begin
                    wr_next = IDLE;
                end
            end
            default: wr_next = IDLE;
        endcase
        if (aresetn) begin
            awready = 1'b0;
            wready  = 1'b0;
            commit  = 1'b0;
            wr_next = IDLE;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            wr_state <= IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (awvalid && awready) begin
            aw_addr_p0 <= awaddr;
        end
        if (wvalid && wready) begin
            w_data_p0 <= wdata;
            w_strb_p0 <= wstrb;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            wr_evt  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_evt <= commit;
            if (commit) begin
                wr_addr <= cmt_addr;
                wr_data <= cmt_data;
            end
        end
    end

    assign bvalid = (wr_state == RESP);
    assign bresp  = (wr_state == RESP) ? WR_RESP : 2'b00;

    // Read channel
    always_comb begin
        rd_next = rd_state;
        arready = 1'b0;
        rd_re   = 1'b0;
        case (rd_state)
            RIDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    rd_re   = 1'b1;
                    rd_next = RDATA;
                end
            end
            RDATA: begin
                if (rready) begin
                    rd_next = RIDLE;
                end
            end
            default: rd_next = RIDLE;
        endcase
        if (aresetn) begin
            arready = 1'b0;
            rd_re   = 1'b0;
            rd_next = RIDLE;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            rd_state <= RIDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    assign rvalid = (rd_state == RDATA);
    assign rresp  = (rd_state == RDATA) ? RD_RESP : 2'b00;

    axi4_lite_regfile #(
        .DATA_BYTES (DATA_BYTES),
        .ADDR_BYTES (ADDR_BYTES),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk   (aclk),
        .rst   (aresetn),
        .we    (commit),
        .waddr (IDX_W'(cmt_addr >> OFF)),
        .wstrb (cmt_strb),
        .wdata (cmt_data),
        .re    (rd_re),
        .raddr (IDX_W'(araddr >> OFF)),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_axi4_lite_slave_bfm.sv
// Bench for axi4_lite_slave_bfm: directed scenarios plus randomized traffic against a word-array model.
module tb_axi4_lite_slave_bfm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [7:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;

    logic        awready, wready, bvalid, arready, rvalid, wr_evt;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, wr_data;
    logic [7:0]  wr_addr;

    logic        awready_t, wready_t, bvalid_t, arready_t, rvalid_t, wr_evt_t;
    logic [1:0]  bresp_t, rresp_t;
    logic [31:0] rdata_t, wr_data_t;
    logic [7:0]  wr_addr_t;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [64];

    axi4_lite_slave_bfm dut (
        .aclk(clk), .aresetn(aresetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .wr_evt(wr_evt), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // Second instance with a non-default write response, driven by the same stimulus.
    axi4_lite_slave_bfm #(.WR_RESP(2'b01)) dut_t (
        .aclk(clk), .aresetn(aresetn),
        .awvalid(awvalid), .awready(awready_t), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready_t), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid_t), .bready(bready), .bresp(bresp_t),
        .arvalid(arvalid), .arready(arready_t), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid_t), .rready(rready), .rdata(rdata_t), .rresp(rresp_t),
        .wr_evt(wr_evt_t), .wr_addr(wr_addr_t), .wr_data(wr_data_t)
    );

    logic twin_same;
    assign twin_same = ({awready, wready, arready, bvalid, rvalid, wr_evt, wr_addr, wr_data, rdata, rresp} ===
                        {awready_t, wready_t, arready_t, bvalid_t, rvalid_t, wr_evt_t, wr_addr_t, wr_data_t, rdata_t, rresp_t});

    task automatic model_clear();
        foreach (model[i]) model[i] = 32'h0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        model[a[7:2]] = (model[a[7:2]] & ~m) | (d & m);
    endtask

    // Drives one write; AW and W each become valid after their own delay. Returns on the cycle after
    // the B handshake; observations are taken on the first cycle after the last address/data handshake.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int bhold,
                             output logic timeout, output logic bv, output logic [1:0] br,
                             output logic [1:0] br_t, output logic evt, output logic evt2,
                             output logic [7:0] wa, output logic [31:0] wd, output int unstable);
        logic aw_done, w_done, aw_hs, w_hs, done;
        int cyc;
        timeout = 0; unstable = 0; aw_done = 0; w_done = 0; cyc = 0; evt2 = 0;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && cyc < 30) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            #1;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) timeout = 1;
        bv = bvalid; br = bresp; br_t = bresp_t; evt = wr_evt; wa = wr_addr; wd = wr_data;
        cyc = 0; done = 0;
        while (!done && cyc < 40) begin
            if (cyc >= bhold) bready = 1;
            #1;
            if (cyc < bhold && (bvalid !== 1'b1 || bresp !== br || awready !== 1'b0 || wready !== 1'b0))
                unstable++;
            done = bvalid && bready;
            @(posedge clk); #1;
            if (cyc == 0) evt2 = wr_evt;
            cyc++;
        end
        bready = 0;
        if (!done) timeout = 1;
    endtask

    task automatic axi_read(input logic [7:0] a, input int rhold,
                            output logic timeout, output logic rv, output logic [31:0] rd,
                            output logic [1:0] rr, output logic [31:0] rd_t, output int unstable);
        logic hs, done;
        int cyc;
        timeout = 0; unstable = 0; hs = 0; cyc = 0;
        araddr = a; arvalid = 1;
        while (!hs && cyc < 20) begin
            #1;
            hs = arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 0;
        if (!hs) timeout = 1;
        rv = rvalid; rd = rdata; rr = rresp; rd_t = rdata_t;
        cyc = 0; done = 0;
        while (!done && cyc < 40) begin
            if (cyc >= rhold) rready = 1;
            #1;
            if (cyc < rhold && (rvalid !== 1'b1 || rdata !== rd || rresp !== rr || arready !== 1'b0))
                unstable++;
            done = rvalid && rready;
            @(posedge clk); #1;
            cyc++;
        end
        rready = 0;
        if (!done) timeout = 1;
    endtask

    task automatic test_reset();
        aresetn = 1;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({awready, wready, arready} !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b want=000", {awready, wready, arready}); end
        total++; if ({bvalid, rvalid, wr_evt} !== 3'b000) begin bad++; $display("FAIL rst_valid got=%b want=000", {bvalid, rvalid, wr_evt}); end
        total++; if (wr_addr !== 8'h0 || wr_data !== 32'h0) begin bad++; $display("FAIL rst_wr_cap got=%h/%h want=0/0", wr_addr, wr_data); end
        total++; if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin bad++; $display("FAIL rst_data got=%h/%b/%b want=0", rdata, bresp, rresp); end
        aresetn = 0;
        model_clear();
        #1;
        total++; if ({awready, wready, arready} !== 3'b111) begin bad++; $display("FAIL rel_ready got=%b want=111", {awready, wready, arready}); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic to, bv, evt, evt2, rv; logic [1:0] br, br_t, rr; logic [7:0] wa; logic [31:0] wd, rd, rd_t; int un;
        axi_write(8'hC4, 32'hDEADBEEF, 4'hF, 0, 0, 0, to, bv, br, br_t, evt, evt2, wa, wd, un);
        model_write(8'hC4, 32'hDEADBEEF, 4'hF);
        total++; if (to !== 1'b0 || bv !== 1'b1) begin bad++; $display("FAIL basic_bvalid got=%b timeout=%b want=1", bv, to); end
        total++; if (br !== 2'b00) begin bad++; $display("FAIL basic_bresp got=%b want=00", br); end
        total++; if (wa !== 8'hC4 || wd !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_wr_cap got=%h/%h want=c4/deadbeef", wa, wd); end
        total++; if (evt !== 1'b1 || evt2 !== 1'b0) begin bad++; $display("FAIL basic_wr_evt got=%b%b want=10", evt, evt2); end
        axi_read(8'hC4, 0, to, rv, rd, rr, rd_t, un);
        total++; if (to !== 1'b0 || rv !== 1'b1) begin bad++; $display("FAIL basic_rvalid got=%b timeout=%b want=1", rv, to); end
        total++; if (rd !== 32'hDEADBEEF || rr !== 2'b00) begin bad++; $display("FAIL basic_rdata got=%h/%b want=deadbeef/00", rd, rr); end
    endtask

    task automatic test_wresp_order();
        logic to, bv, evt, evt2, rv; logic [1:0] br, br_t, rr; logic [7:0] wa; logic [31:0] wd, rd, rd_t; int un;
        axi_write(8'hC4, 32'hABCD1234, 4'hF, 3, 0, 0, to, bv, br, br_t, evt, evt2, wa, wd, un);
        model_write(8'hC4, 32'hABCD1234, 4'hF);
        total++; if (to !== 1'b0 || bv !== 1'b1 || evt !== 1'b1) begin bad++; $display("FAIL wfirst_resp got=bv%b evt%b timeout=%b want=1/1/0", bv, evt, to); end
        total++; if (br_t !== 2'b01) begin bad++; $display("FAIL wfirst_bresp01 got=%b want=01", br_t); end
        total++; if (br !== 2'b00) begin bad++; $display("FAIL wfirst_bresp00 got=%b want=00", br); end
        axi_read(8'hC4, 0, to, rv, rd, rr, rd_t, un);
        total++; if (rd !== 32'hABCD1234 || rd_t !== 32'hABCD1234) begin bad++; $display("FAIL wfirst_rdata got=%h/%h want=abcd1234", rd, rd_t); end
        axi_write(8'h08, 32'h0BADF00D, 4'hF, 0, 4, 0, to, bv, br, br_t, evt, evt2, wa, wd, un);
        model_write(8'h08, 32'h0BADF00D, 4'hF);
        total++; if (to !== 1'b0 || bv !== 1'b1 || wa !== 8'h08 || wd !== 32'h0BADF00D) begin bad++; $display("FAIL awfirst_resp got=bv%b %h/%h want=1 08/0badf00d", bv, wa, wd); end
    endtask

    task automatic test_strobe();
        logic to, bv, evt, evt2, rv; logic [1:0] br, br_t, rr; logic [7:0] wa; logic [31:0] wd, rd, rd_t; int un;
        axi_write(8'h10, 32'h11223344, 4'hF, 0, 0, 0, to, bv, br, br_t, evt, evt2, wa, wd, un);
        model_write(8'h10, 32'h11223344, 4'hF);
        axi_write(8'h10, 32'hFFFFFFFF, 4'b0101, 1, 0, 0, to, bv, br, br_t, evt, evt2, wa, wd, un);
        model_write(8'h10, 32'hFFFFFFFF, 4'b0101);
        axi_read(8'h10, 0, to, rv, rd, rr, rd_t, un);
        total++; if (rd !== 32'h11FF33FF) begin bad++; $display("FAIL strobe_0101 got=%h want=11ff33ff", rd); end
        axi_write(8'h13, 32'h99999999, 4'b0000, 0, 0, 0, to, bv, br, br_t, evt, evt2, wa, wd, un);
        model_write(8'h13, 32'h99999999, 4'b0000);
        total++; if (bv !== 1'b1 || evt !== 1'b1 || wa !== 8'h13) begin bad++; $display("FAIL strobe_zero_resp got=bv%b evt%b addr%h want=1/1/13", bv, evt, wa); end
        axi_read(8'h11, 0, to, rv, rd, rr, rd_t, un);
        total++; if (rd !== model[4]) begin bad++; $display("FAIL strobe_zero_keep got=%h want=%h", rd, model[4]); end
    endtask

    task automatic test_backpressure();
        logic to, bv, evt, evt2, rv; logic [1:0] br, br_t, rr; logic [7:0] wa; logic [31:0] wd, rd, rd_t; int un;
        axi_write(8'h24, 32'h5A5AA5A5, 4'hF, 0, 0, 5, to, bv, br, br_t, evt, evt2, wa, wd, un);
        model_write(8'h24, 32'h5A5AA5A5, 4'hF);
        total++; if (to !== 1'b0 || un != 0) begin bad++; $display("FAIL bhold_stable got=%0d unstable timeout=%b want=0", un, to); end
        total++; if (evt2 !== 1'b0) begin bad++; $display("FAIL bhold_evt_pulse got=%b want=0", evt2); end
        axi_read(8'h24, 5, to, rv, rd, rr, rd_t, un);
        total++; if (to !== 1'b0 || un != 0) begin bad++; $display("FAIL rhold_stable got=%0d unstable timeout=%b want=0", un, to); end
        total++; if (rd !== 32'h5A5AA5A5) begin bad++; $display("FAIL rhold_rdata got=%h want=5a5aa5a5", rd); end
    endtask

    task automatic test_collision();
        logic to, rv; logic [1:0] rr; logic [31:0] rd, rd_t, old; int un;
        old = model[16];
        awaddr = 8'h40; wdata = 32'h12345678; wstrb = 4'hF; araddr = 8'h42;
        awvalid = 1; wvalid = 1; arvalid = 1;
        #1;
        total++; if ({awready, wready, arready} !== 3'b111) begin bad++; $display("FAIL coll_ready got=%b want=111", {awready, wready, arready}); end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        total++; if (rvalid !== 1'b1 || bvalid !== 1'b1) begin bad++; $display("FAIL coll_valids got=r%b b%b want=1/1", rvalid, bvalid); end
        total++; if (rdata !== old) begin bad++; $display("FAIL coll_old_data got=%h want=%h", rdata, old); end
        bready = 1; rready = 1;
        @(posedge clk); #1;
        bready = 0; rready = 0;
        model_write(8'h40, 32'h12345678, 4'hF);
        axi_read(8'h40, 0, to, rv, rd, rr, rd_t, un);
        total++; if (rd !== model[16]) begin bad++; $display("FAIL coll_new_data got=%h want=%h", rd, model[16]); end
    endtask

    task automatic test_reset_mid();
        logic to, rv; logic [1:0] rr; logic [31:0] rd, rd_t; int un;
        awaddr = 8'h20; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0;
        @(posedge clk); #1;
        aresetn = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        aresetn = 0;
        model_clear();
        total++; if (bvalid !== 1'b0 || wr_evt !== 1'b0) begin bad++; $display("FAIL rmid_no_resp got=bv%b evt%b want=0/0", bvalid, wr_evt); end
        wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1;
        #1;
        total++; if ({awready, wready} !== 2'b11) begin bad++; $display("FAIL rmid_idle_ready got=%b want=11", {awready, wready}); end
        @(posedge clk); #1;
        wvalid = 0;
        total++; if (bvalid !== 1'b0 || wr_evt !== 1'b0) begin bad++; $display("FAIL rmid_no_commit got=bv%b evt%b want=0/0", bvalid, wr_evt); end
        axi_read(8'h20, 0, to, rv, rd, rr, rd_t, un);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rmid_rdata got=%h want=0", rd); end
        axi_read(8'h10, 0, to, rv, rd, rr, rd_t, un);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rmid_cleared got=%h want=0", rd); end
        // finish the dangling W so the write FSM is idle again
        awaddr = 8'hFC; awvalid = 1; bready = 1;
        @(posedge clk); #1;
        awvalid = 0;
        @(posedge clk); #1;
        bready = 0;
        model_write(8'hFC, 32'h77777777, 4'hF);
    endtask

    task automatic test_random();
        logic to, bv, evt, evt2, rv; logic [1:0] br, br_t, rr; logic [7:0] wa, a; logic [31:0] wd, rd, rd_t, d;
        logic [3:0] s; int un;
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                          to, bv, br, br_t, evt, evt2, wa, wd, un);
                model_write(a, d, s);
                total++; if (to !== 1'b0 || bv !== 1'b1 || br !== 2'b00 || br_t !== 2'b01) begin bad++; $display("FAIL rnd_wresp n=%0d got=bv%b br%b/%b to%b want=1 00/01 0", n, bv, br, br_t, to); end
                total++; if (evt !== 1'b1 || wa !== a || wd !== d) begin bad++; $display("FAIL rnd_wcap n=%0d got=%b %h/%h want=1 %h/%h", n, evt, wa, wd, a, d); end
            end else begin
                axi_read(a, $urandom_range(0, 2), to, rv, rd, rr, rd_t, un);
                total++; if (to !== 1'b0 || rv !== 1'b1 || rd !== model[a[7:2]] || rr !== 2'b00) begin bad++; $display("FAIL rnd_read n=%0d addr=%h got=%h/%b want=%h/00", n, a, rd, rr, model[a[7:2]]); end
                total++; if (rd_t !== rd) begin bad++; $display("FAIL rnd_twin_rdata n=%0d got=%h want=%h", n, rd_t, rd); end
            end
            total++; if (twin_same !== 1'b1) begin bad++; $display("FAIL rnd_twin_state n=%0d got=%b want=1", n, twin_same); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wresp_order();
        test_strobe();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_bfm.md
AXI4_LITE_SLAVE_BFM -- requirements
Module: axi4_lite_slave_bfm

Interface
REQ-001 Parameter DATA_BYTES, default 4: bus data width in bytes (data width = 8*DATA_BYTES).
REQ-002 Parameter ADDR_BYTES, default 1: bus address width in bytes (address width = 8*ADDR_BYTES).
REQ-003 Parameter WR_RESP, default 2'b00: BRESP code returned for every write.
REQ-004 Parameter RD_RESP, default 2'b00: RRESP code returned for every read.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 aclk  in  1  sole clock; all logic rising-edge.
REQ-007 aresetn  in  1  synchronous reset, asserted when 1; name kept for codebase port compatibility.
REQ-008 awvalid/awready  in/out  1/1  write-address handshake.
REQ-009 awaddr  in  8*ADDR_BYTES  write byte address.
REQ-010 awprot  in  3  accepted, ignored.
REQ-011 wvalid/wready  in/out  1/1  write-data handshake.
REQ-012 wdata  in  8*DATA_BYTES  write data.
REQ-013 wstrb  in  DATA_BYTES  byte enables.
REQ-014 bvalid/bready  out/in  1/1  write-response handshake.
REQ-015 bresp  out  2  write response code.
REQ-016 arvalid/arready  in/out  1/1  read-address handshake.
REQ-017 araddr  in  8*ADDR_BYTES  read byte address.
REQ-018 arprot  in  3  accepted, ignored.
REQ-019 rvalid/rready  out/in  1/1  read-data handshake.
REQ-020 rdata  out  8*DATA_BYTES  read data.
REQ-021 rresp  out  2  read response code.
REQ-022 wr_evt  out  1  one-cycle pulse when a write commits.
REQ-023 wr_addr  out  8*ADDR_BYTES  captured address of last committed write.
REQ-024 wr_data  out  8*DATA_BYTES  captured wdata of last committed write.

Function
REQ-025 Storage: 2^(8*ADDR_BYTES)/DATA_BYTES words; word index = address with low log2(DATA_BYTES) bits dropped; unaligned low bits ignored.
REQ-026 Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP.
REQ-027 IDLE: awready=1, wready=1; AW only -> HAVE_AW; W only -> HAVE_W; both same cycle -> commit, then RESP.
REQ-028 HAVE_AW: awready=0, wready=1; on W handshake -> commit, then RESP. HAVE_W mirrors with awready=1, wready=0.
REQ-029 Commit: update only bytes whose wstrb bit is 1; wr_evt=1 for exactly that cycle; wr_addr/wr_data load the captured values.
REQ-030 RESP: bvalid=1, bresp=WR_RESP, awready=wready=0; stay until bready=1, then IDLE; bvalid asserts the cycle after the last of AW/W handshakes.
REQ-031 Read FSM states: RIDLE, RDATA.
REQ-032 RIDLE: arready=1; on AR handshake, register addressed word into rdata, rresp=RD_RESP, go RDATA; rvalid asserts the next cycle.
REQ-033 RDATA: arready=0, rvalid=1, rdata/rresp stable until rready=1, then RIDLE.
REQ-034 Read and write channels operate independently and concurrently.
REQ-035 A read whose AR handshake coincides with a commit to the same word returns the pre-write value.
REQ-036 wstrb=0 commits with no storage change but still produces a response and wr_evt.

Reset
REQ-037 While aresetn=1: write FSM=IDLE, read FSM=RIDLE; all valids/readies=0; bresp, rresp, rdata, wr_addr, wr_data=0; wr_evt=0; storage cleared to 0.
REQ-038 First cycle after release: awready=wready=arready=1.
REQ-039 Reset asserted mid-transaction abandons it with no commit and no response.

Structure
REQ-040 Package axi4_lite_pkg holds the response codes OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11, plus both FSM state enums.
REQ-041 Storage and byte-enable write logic live in sub-module axi4_lite_regfile, with one write port and one registered read port.

Verification
REQ-042 Write 0xDEADBEEF to 0xC4 with wstrb=F, AW and W simultaneous -> bvalid the next cycle, bresp=00, wr_addr=0xC4, wr_data=0xDEADBEEF.
REQ-043 Then read 0xC4 -> rvalid one cycle after AR handshake, rdata=0xDEADBEEF, rresp=00.
REQ-044 With WR_RESP=2'b01, W issued 3 cycles before AW, addr 0xC4, data 0xABCD1234 -> bresp=01, and a subsequent read returns 0xABCD1234.
REQ-045 Write 0x11223344 to 0x10, then 0xFFFFFFFF with wstrb=4'b0101 -> reading 0x10 returns 0x11FF33FF.
REQ-046 Hold bready=0 for 5 cycles and rready=0 for 5 cycles -> bvalid/rvalid, bresp and rdata stay stable, and awready/arready stay 0 throughout.
REQ-047 Assert reset mid-write after AW only -> no commit, and a subsequent read of that address returns 0.
